// File: rtl/encoder_gray_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | encoder_gray_if : input/output handshake bundle of the Gray encoder       |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
interface encoder_gray_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] data_o;
  logic             wrap_o;

  modport master (
    output in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, wrap_o
  );

  modport slave (
    input  in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, wrap_o
  );
endinterface
`default_nettype wire

// File: rtl/encoder_gray.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | encoder_gray : binary-to-Gray encoder with a free-running Gray count mode |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module encoder_gray #(
  parameter int WIDTH = 8
) (
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  input  wire logic [2:0] en_i,
  input  wire logic       mode_i,
  encoder_gray_if.slave   bus
);
  localparam logic [2:0] C_EN_CODE = 3'b100;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_wrap;
  logic [WIDTH-1:0] r_cnt;

  logic w_enabled;
  logic w_slot_free;
  logic w_in_ready;
  logic w_load_enc;
  logic w_load_cnt;

  assign w_enabled   = (en_i == C_EN_CODE);
  assign w_slot_free = !r_valid || bus.out_ready_i;
  // Gated by rst_ni so the input side looks closed while reset is asserted.
  assign w_in_ready  = rst_ni && w_enabled && !mode_i && w_slot_free;
  assign w_load_enc  = bus.in_valid_i && w_in_ready;
  assign w_load_cnt  = w_enabled && mode_i && w_slot_free;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load_enc) begin
      r_data  <= bus.data_i ^ (bus.data_i >> 1);
      r_valid <= 1'b1;
      r_wrap  <= 1'b0;
    end else if (w_load_cnt) begin
      r_data  <= r_cnt ^ (r_cnt >> 1);
      r_valid <= 1'b1;
      r_wrap  <= &r_cnt;
      r_cnt   <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_valid;
  assign bus.data_o      = r_data;
  assign bus.wrap_o      = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_encoder_gray.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_encoder_gray : directed self-checking bench for encoder_gray           |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_encoder_gray;
  logic       clk;
  logic       rst_n;
  logic [2:0] en;
  logic       mode;
  int         checks;
  int         errors;

  encoder_gray_if #(.WIDTH(8)) bus ();

  encoder_gray #(.WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .mode_i (mode),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, elapsed=%0t limit=2000000", $time);
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 3'b100; mode = 1'b0;
    bus.in_valid_i = 1'b1; bus.data_i = 8'hA5; bus.out_ready_i = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.data_o); end
    checks++;
    if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid_o); end
    checks++;
    if (bus.wrap_o !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap_o); end
    checks++;
    if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready_o); end
    bus.in_valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_encode();
    logic [7:0] spot_in  [3] = '{8'h05, 8'h80, 8'hFF};
    logic [7:0] spot_exp [3] = '{8'h07, 8'hC0, 8'h80};
    bus.in_valid_i = 1'b1;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      b = 8'(v);
      bus.data_i = b;
      @(negedge clk);
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.data_o !== (b ^ (b >> 1)) || bus.wrap_o !== 1'b0) begin
        errors++;
        $display("FAIL encode_sweep in=%h got v=%b d=%h w=%b exp v=1 d=%h w=0",
                 b, bus.out_valid_o, bus.data_o, bus.wrap_o, b ^ (b >> 1));
      end
    end
    for (int i = 0; i < 3; i++) begin
      bus.data_i = spot_in[i];
      @(negedge clk);
      checks++;
      if (bus.data_o !== spot_exp[i] || bus.wrap_o !== 1'b0) begin
        errors++;
        $display("FAIL encode_spot in=%h got d=%h w=%b exp d=%h w=0",
                 spot_in[i], bus.data_o, bus.wrap_o, spot_exp[i]);
      end
    end
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL encode_idle_valid got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure();
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.data_i      = 8'h03;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.data_o !== 8'h02) begin
      errors++; $display("FAIL bp_first got v=%b d=%h exp v=1 d=02", bus.out_valid_o, bus.data_o);
    end
    checks++;
    if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low got=%b exp=0", bus.in_ready_o); end
    bus.data_i = 8'h04;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.data_o !== 8'h02) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=02", bus.out_valid_o, bus.data_o);
    end
    bus.out_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_in_ready_high got=%b exp=1", bus.in_ready_o); end
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.data_o !== 8'h06) begin
      errors++; $display("FAIL bp_release got v=%b d=%h exp v=1 d=06", bus.out_valid_o, bus.data_o);
    end
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_count();
    logic [7:0] first [8] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
    logic [7:0] prev;
    logic [7:0] k8;
    logic [7:0] exp_d;
    prev = 8'h00;
    mode = 1'b1;
    bus.data_i = 8'hFF;
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      k8 = 8'(k);
      exp_d = (k < 8) ? first[k] : (k8 ^ (k8 >> 1));
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.data_o !== exp_d || bus.wrap_o !== (k == 255)) begin
        errors++;
        $display("FAIL count_beat idx=%0d got v=%b d=%h w=%b exp v=1 d=%h w=%b",
                 k, bus.out_valid_o, bus.data_o, bus.wrap_o, exp_d, (k == 255));
      end
      if (k > 0) begin
        checks++;
        if ($countones(bus.data_o ^ prev) != 1) begin
          errors++;
          $display("FAIL count_one_bit idx=%0d got prev=%h cur=%h exp one-bit change", k, prev, bus.data_o);
        end
      end
      prev = bus.data_o;
    end
  endtask

  task automatic test_enable();
    logic [2:0] codes [4] = '{3'b101, 3'b111, 3'b110, 3'b000};
    // Pending beat is gray(1)=0x01 with the counter parked at 2.
    bus.out_ready_i = 1'b0;
    mode = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.data_i = 8'h55;
    for (int c = 0; c < 4; c++) begin
      en = codes[c];
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.data_o !== 8'h01) begin
          errors++;
          $display("FAIL en_hold en=%b got r=%b v=%b d=%h exp r=0 v=1 d=01",
                   en, bus.in_ready_o, bus.out_valid_o, bus.data_o);
        end
      end
    end
    bus.out_ready_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL en_drain got v=%b r=%b exp v=0 r=0", bus.out_valid_o, bus.in_ready_o);
      end
    end
    en = 3'b100;
    mode = 1'b1;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.data_o !== 8'h03 || bus.wrap_o !== 1'b0) begin
      errors++; $display("FAIL en_resume got v=%b d=%h w=%b exp v=1 d=03 w=0", bus.out_valid_o, bus.data_o, bus.wrap_o);
    end
    @(negedge clk);
    checks++;
    if (bus.data_o !== 8'h02) begin errors++; $display("FAIL en_resume2 got=%h exp=02", bus.data_o); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.data_o !== 8'h00 || bus.out_valid_o !== 1'b0 || bus.wrap_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got d=%h v=%b w=%b r=%b exp d=00 v=0 w=0 r=0",
               bus.data_o, bus.out_valid_o, bus.wrap_o, bus.in_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.data_o !== 8'h00) begin
      errors++; $display("FAIL mid_reset_restart got v=%b d=%h exp v=1 d=00", bus.out_valid_o, bus.data_o);
    end
    @(negedge clk);
    checks++;
    if (bus.data_o !== 8'h01) begin errors++; $display("FAIL mid_reset_next got=%h exp=01", bus.data_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_encode();
    test_backpressure();
    test_count();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
